inciso3_sweep_ctrl: RTL and testbench
=====================================

# inciso3_sweep_ctrl

Sequencer that exhaustively exercises the five-input inciso-3 sum-of-products block. It drives all 32 combinations of X, Y, Z, K, M in ascending order and waits a programmable settle time per vector. On each vector it samples the block's two outputs (out_7 and S_OR3). It reports how many vectors produce a 1, and whether and where the two implementations disagree. It sits between the board's start button/debounce logic and the combinational function block, and its results feed the display logic.

## Interface
Parameters:
- SETTLE_CYCLES, default 1: clock cycles each vector is held before sampling; legal range 1..15.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  sweep request, level-sampled in IDLE only
- abort  input  1  synchronous sweep cancel
- out_7_in  input  1  out_7 from function block
- s_or3_in  input  1  S_OR3 from function block
- X, Y, Z, K, M  output  1 each  registered vector to function block
- busy  output  1  high while sweeping
- done  output  1  one-cycle pulse at sweep completion
- ones_count  output  6  vectors with out_7_in = 1 (0..32)
- mismatch_count  output  6  vectors with out_7_in != s_or3_in (0..32)
- mismatch_flag  output  1  at least one mismatch in last sweep
- first_mismatch  output  5  lowest mismatching vector index; 0 when mismatch_flag = 0

## Operation
- 5-bit index idx. Vector mapping: X = idx[4], Y = idx[3], Z = idx[2], K = idx[1], M = idx[0].
- Vector outputs are all 0 in IDLE and DONE, and equal idx in SETTLE.
- Settle counter scnt is 4 bits.
- FSM states:
  - IDLE:
    - If abort = 1, stay in IDLE; start is ignored.
    - Else if start = 1, clear all counters and flags, set idx = 0 and scnt = 0, and go to SETTLE.
  - SETTLE:
    - If abort = 1, go to IDLE. Set idx = 0. Do not pulse done. Counters hold their partial values.
    - Else if scnt < SETTLE_CYCLES-1, increment scnt.
    - Else sample the inputs. Increment ones_count if out_7_in = 1. If out_7_in != s_or3_in: increment mismatch_count, and if mismatch_flag = 0, set mismatch_flag = 1 and first_mismatch = idx. Then set scnt = 0.
    - After sampling, if idx = 31 go to DONE; otherwise increment idx.
  - DONE: assert done for exactly one cycle, then go to IDLE. start and abort are ignored in DONE.
- start is ignored in SETTLE.
- Result outputs hold after a sweep until the next accepted start.
- Counters never wrap: the maximum value is 32, which fits in 6 bits.
- Samples taken on the final sweep edge are included in the results before done is asserted.

## Timing
- Reset values: state IDLE, idx 0, scnt 0, X/Y/Z/K/M 0, busy 0, done 0, ones_count 0, mismatch_count 0, mismatch_flag 0, first_mismatch 0.
- Reset asserted mid-sweep forces all of the above immediately, regardless of clk.
- busy = 1 exactly in SETTLE. done = 1 exactly in DONE.
- Start accepted at edge T0 gives:
  - Vector 0 visible after T0.
  - Sample for vector n at edge T0 + (n+1)·SETTLE_CYCLES.
  - busy falls and done rises after edge T0 + 32·SETTLE_CYCLES.
  - done falls one edge later.
- Sweep latency is 32·SETTLE_CYCLES + 1 cycles from the start edge to the end of the done pulse.
- The earliest restart is start sampled in the cycle after done, since done occurs in the DONE state and start is only accepted in IDLE.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Reset mid-sweep: reset asserted at idx 10 → all outputs 0 immediately; FSM returns to IDLE; no done pulse.
- Nominal sweep: SETTLE_CYCLES = 1, correct function block connected, start pulse → X..M step 00000 to 11111 one per cycle; done pulse 33 cycles after the start edge; ones_count = 15, mismatch_count = 0, mismatch_flag = 0, first_mismatch = 0.
- Forced disagreement: out_7_in tied to 1, s_or3_in tied to 0 → ones_count = 32, mismatch_count = 32, mismatch_flag = 1, first_mismatch = 0.
- Single fault at vector 0b10110 (s_or3_in inverted only when idx = 22), SETTLE_CYCLES = 3 → mismatch_count = 1, first_mismatch = 22; each vector is held 3 cycles; done pulse 97 cycles after the start edge.
- Abort: abort asserted while idx = 5 → next cycle state IDLE, busy 0, vector outputs 0, no done pulse, ones_count holds its partial value. A subsequent start clears the counters and sweeps from vector 0.
- Simultaneous and ignored requests:
  - start and abort both high in IDLE → no sweep.
  - start held high throughout a sweep → a second sweep begins only after the done pulse.
  - start pulse during SETTLE → idx is not restarted.

Source files
------------

// File: rtl/inciso3_sweep_ctrl_if.sv
// Signal bundle between the inciso-3 sweep controller and its surroundings:
// start/abort from the button logic, the function block's vector and outputs, and the results.
interface inciso3_sweep_ctrl_if;
    logic       start;
    logic       abort;
    logic       out_7_in;
    logic       s_or3_in;
    logic       X;
    logic       Y;
    logic       Z;
    logic       K;
    logic       M;
    logic       busy;
    logic       done;
    logic [5:0] ones_count;
    logic [5:0] mismatch_count;
    logic       mismatch_flag;
    logic [4:0] first_mismatch;

    modport master (
        output start, abort, out_7_in, s_or3_in,
        input  X, Y, Z, K, M, busy, done,
        input  ones_count, mismatch_count, mismatch_flag, first_mismatch
    );

    modport slave (
        input  start, abort, out_7_in, s_or3_in,
        output X, Y, Z, K, M, busy, done,
        output ones_count, mismatch_count, mismatch_flag, first_mismatch
    );
endinterface

// File: rtl/inciso3_sweep_ctrl.sv
// Walks all 32 input vectors of the inciso-3 block, holding each for SETTLE_CYCLES,
// and tallies ones and out_7/S_OR3 disagreements. Every output is a register.
module inciso3_sweep_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input logic                 clk,
    input logic                 rst_n,
    inciso3_sweep_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [3:0] SCNT_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [5:0] CNT_MAX   = 6'd32;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [4:0] r_idx;
    logic [4:0] w_idx_nxt;
    logic [3:0] r_scnt;
    logic [3:0] w_scnt_nxt;
    logic [5:0] r_ones;
    logic [5:0] w_ones_nxt;
    logic [5:0] r_mm;
    logic [5:0] w_mm_nxt;
    logic       r_flag;
    logic       w_flag_nxt;
    logic [4:0] r_first;
    logic [4:0] w_first_nxt;
    logic [4:0] r_vec;
    logic       r_busy;
    logic       r_done;

    // Next-state and datapath update; abort wins over sampling in SETTLE.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_scnt_nxt  = r_scnt;
        w_ones_nxt  = r_ones;
        w_mm_nxt    = r_mm;
        w_flag_nxt  = r_flag;
        w_first_nxt = r_first;
        case (r_state)
            ST_IDLE: begin
                if (bus.abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (bus.start) begin
                    w_state_nxt = ST_SETTLE;
                    w_idx_nxt   = 5'd0;
                    w_scnt_nxt  = 4'd0;
                    w_ones_nxt  = 6'd0;
                    w_mm_nxt    = 6'd0;
                    w_flag_nxt  = 1'b0;
                    w_first_nxt = 5'd0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (bus.abort) begin
                    w_state_nxt = ST_IDLE;
                    w_idx_nxt   = 5'd0;
                    w_scnt_nxt  = 4'd0;
                end else if (r_scnt < SCNT_LAST) begin
                    w_scnt_nxt = r_scnt + 4'd1;
                end else begin
                    w_scnt_nxt = 4'd0;
                    if (bus.out_7_in && (r_ones != CNT_MAX)) begin
                        w_ones_nxt = r_ones + 6'd1;
                    end else begin
                        w_ones_nxt = r_ones;
                    end
                    if ((bus.out_7_in != bus.s_or3_in) && (r_mm != CNT_MAX)) begin
                        w_mm_nxt = r_mm + 6'd1;
                    end else begin
                        w_mm_nxt = r_mm;
                    end
                    // Only the lowest disagreeing index is latched.
                    if ((bus.out_7_in != bus.s_or3_in) && !r_flag) begin
                        w_flag_nxt  = 1'b1;
                        w_first_nxt = r_idx;
                    end else begin
                        w_flag_nxt  = r_flag;
                        w_first_nxt = r_first;
                    end
                    if (r_idx == 5'd31) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_idx_nxt = r_idx + 5'd1;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = 5'd0;
                w_scnt_nxt  = 4'd0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = 5'd0;
                w_scnt_nxt  = 4'd0;
            end
        endcase
    end

    // State, datapath and output registers; outputs follow the next state so they stay registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= 5'd0;
            r_scnt  <= 4'd0;
            r_ones  <= 6'd0;
            r_mm    <= 6'd0;
            r_flag  <= 1'b0;
            r_first <= 5'd0;
            r_vec   <= 5'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_scnt  <= w_scnt_nxt;
            r_ones  <= w_ones_nxt;
            r_mm    <= w_mm_nxt;
            r_flag  <= w_flag_nxt;
            r_first <= w_first_nxt;
            r_vec   <= (w_state_nxt == ST_SETTLE) ? w_idx_nxt : 5'd0;
            r_busy  <= (w_state_nxt == ST_SETTLE);
            r_done  <= (w_state_nxt == ST_DONE);
        end
    end

    assign bus.X              = r_vec[4];
    assign bus.Y              = r_vec[3];
    assign bus.Z              = r_vec[2];
    assign bus.K              = r_vec[1];
    assign bus.M              = r_vec[0];
    assign bus.busy           = r_busy;
    assign bus.done           = r_done;
    assign bus.ones_count     = r_ones;
    assign bus.mismatch_count = r_mm;
    assign bus.mismatch_flag  = r_flag;
    assign bus.first_mismatch = r_first;
endmodule

// File: tb/tb_inciso3_sweep_ctrl.sv
// Bench for inciso3_sweep_ctrl: two instances (settle 1 and 3) driven by truth-table models of the
// function block, with results predicted from the truth tables themselves.
module tb_inciso3_sweep_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    inciso3_sweep_ctrl_if if_a();
    inciso3_sweep_ctrl_if if_b();

    inciso3_sweep_ctrl #(.SETTLE_CYCLES(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    inciso3_sweep_ctrl #(.SETTLE_CYCLES(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));

    localparam logic [31:0] NOMINAL = 32'hA5C3_1E0E;

    logic        tb_start;
    logic        tb_abort;
    logic        sel_b;
    logic [31:0] out7_mask;
    logic [31:0] sor3_mask;
    int          n_checks = 0;
    int          n_fail   = 0;

    logic [4:0] vec_a;
    logic [4:0] vec_b;
    assign vec_a = {if_a.X, if_a.Y, if_a.Z, if_a.K, if_a.M};
    assign vec_b = {if_b.X, if_b.Y, if_b.Z, if_b.K, if_b.M};

    assign if_a.start    = tb_start & ~sel_b;
    assign if_a.abort    = tb_abort & ~sel_b;
    assign if_b.start    = tb_start & sel_b;
    assign if_b.abort    = tb_abort & sel_b;
    assign if_a.out_7_in = out7_mask[vec_a];
    assign if_a.s_or3_in = sor3_mask[vec_a];
    assign if_b.out_7_in = out7_mask[vec_b];
    assign if_b.s_or3_in = sor3_mask[vec_b];

    logic [4:0] o_vec;
    logic       o_busy;
    logic       o_done;
    logic [5:0] o_ones;
    logic [5:0] o_mm;
    logic       o_flag;
    logic [4:0] o_first;
    assign o_vec   = sel_b ? vec_b : vec_a;
    assign o_busy  = sel_b ? if_b.busy : if_a.busy;
    assign o_done  = sel_b ? if_b.done : if_a.done;
    assign o_ones  = sel_b ? if_b.ones_count : if_a.ones_count;
    assign o_mm    = sel_b ? if_b.mismatch_count : if_a.mismatch_count;
    assign o_flag  = sel_b ? if_b.mismatch_flag : if_a.mismatch_flag;
    assign o_first = sel_b ? if_b.first_mismatch : if_a.first_mismatch;

    // Reference model: counts over the first n truth-table rows.
    function automatic int pop_below(input logic [31:0] m, input int n);
        int c = 0;
        for (int i = 0; i < n; i++) if (m[i]) c++;
        return c;
    endfunction

    function automatic int lowest_set(input logic [31:0] m);
        for (int i = 0; i < 32; i++) if (m[i]) return i;
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Caller has just passed the start-accept edge T0.
    task automatic sweep_and_check(input string tag, input int s, input bit hold, input int pulse_at);
        int          last = 32 * s;
        logic [31:0] diff = out7_mask ^ sor3_mask;
        int          e_ones = pop_below(out7_mask, 32);
        int          e_mm = pop_below(diff, 32);
        logic        e_flag = (diff != 32'd0);
        int          e_first = lowest_set(diff);
        n_checks++;
        if (o_busy !== 1'b1 || o_done !== 1'b0 || o_vec !== 5'd0) begin
            n_fail++;
            $display("FAIL %s_t0: busy=%b done=%b vec=%0d, want busy=1 done=0 vec=0", tag, o_busy, o_done, o_vec);
        end
        for (int k = 1; k <= last; k++) begin
            tb_start = hold || (k == pulse_at);
            tick();
            if (k < last) begin
                n_checks++;
                if (o_busy !== 1'b1 || o_done !== 1'b0 || o_vec !== 5'(k / s)) begin
                    n_fail++;
                    $display("FAIL %s_step k=%0d: busy=%b done=%b vec=%0d, want busy=1 done=0 vec=%0d",
                             tag, k, o_busy, o_done, o_vec, k / s);
                end
            end else begin
                n_checks++;
                if (o_busy !== 1'b0 || o_done !== 1'b1 || o_vec !== 5'd0) begin
                    n_fail++;
                    $display("FAIL %s_done_rise: busy=%b done=%b vec=%0d, want busy=0 done=1 vec=0",
                             tag, o_busy, o_done, o_vec);
                end
            end
        end
        n_checks++;
        if (o_ones !== 6'(e_ones) || o_mm !== 6'(e_mm) || o_flag !== e_flag || o_first !== 5'(e_first)) begin
            n_fail++;
            $display("FAIL %s_results: ones=%0d mm=%0d flag=%b first=%0d, want ones=%0d mm=%0d flag=%b first=%0d",
                     tag, o_ones, o_mm, o_flag, o_first, e_ones, e_mm, e_flag, e_first);
        end
        tb_start = hold;
        tick();
        n_checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b0 || o_ones !== 6'(e_ones) || o_first !== 5'(e_first)) begin
            n_fail++;
            $display("FAIL %s_done_fall: done=%b busy=%b ones=%0d first=%0d, want done=0 busy=0 ones=%0d first=%0d",
                     tag, o_done, o_busy, o_ones, o_first, e_ones, e_first);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tb_start = 1'b0;
        tb_abort = 1'b0;
        sel_b = 1'b0;
        out7_mask = NOMINAL;
        sor3_mask = NOMINAL;
        #12;
        for (int d = 0; d < 2; d++) begin
            sel_b = d[0];
            #1;
            n_checks++;
            if (o_vec !== 5'd0 || o_busy !== 1'b0 || o_done !== 1'b0 || o_ones !== 6'd0 ||
                o_mm !== 6'd0 || o_flag !== 1'b0 || o_first !== 5'd0) begin
                n_fail++;
                $display("FAIL reset_state dut%0d: vec=%0d busy=%b done=%b ones=%0d mm=%0d flag=%b first=%0d, want all 0",
                         d, o_vec, o_busy, o_done, o_ones, o_mm, o_flag, o_first);
            end
        end
        sel_b = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_nominal();
        sel_b = 1'b0;
        out7_mask = NOMINAL;
        sor3_mask = NOMINAL;
        tb_start = 1'b1;
        tick();
        sweep_and_check("nominal", 1, 1'b0, -1);
    endtask

    task automatic test_forced_disagreement();
        sel_b = 1'b0;
        out7_mask = 32'hFFFF_FFFF;
        sor3_mask = 32'h0000_0000;
        tb_start = 1'b1;
        tick();
        sweep_and_check("forced", 1, 1'b0, -1);
    endtask

    // Settle 3, one bad row at 22, plus a stray start pulse mid-sweep that must be ignored.
    task automatic test_single_fault();
        sel_b = 1'b1;
        out7_mask = NOMINAL;
        sor3_mask = NOMINAL ^ (32'd1 << 22);
        tb_start = 1'b1;
        tick();
        sweep_and_check("single_fault", 3, 1'b0, 40);
        sel_b = 1'b0;
    endtask

    task automatic test_abort();
        logic [31:0] diff;
        sel_b = 1'b0;
        out7_mask = $urandom | 32'h0000_0003;
        sor3_mask = $urandom;
        diff = out7_mask ^ sor3_mask;
        tb_start = 1'b1;
        tick();
        tb_start = 1'b0;
        repeat (5) tick();
        n_checks++;
        if (o_vec !== 5'd5 || o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_pre: vec=%0d busy=%b, want vec=5 busy=1", o_vec, o_busy);
        end
        tb_abort = 1'b1;
        tick();
        tb_abort = 1'b0;
        n_checks++;
        if (o_busy !== 1'b0 || o_vec !== 5'd0 || o_done !== 1'b0 ||
            o_ones !== 6'(pop_below(out7_mask, 5)) || o_mm !== 6'(pop_below(diff, 5))) begin
            n_fail++;
            $display("FAIL abort_state: busy=%b vec=%0d done=%b ones=%0d mm=%0d, want busy=0 vec=0 done=0 ones=%0d mm=%0d",
                     o_busy, o_vec, o_done, o_ones, o_mm, pop_below(out7_mask, 5), pop_below(diff, 5));
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (o_done !== 1'b0 || o_busy !== 1'b0 || o_ones !== 6'(pop_below(out7_mask, 5))) begin
                n_fail++;
                $display("FAIL abort_hold: done=%b busy=%b ones=%0d, want done=0 busy=0 ones=%0d",
                         o_done, o_busy, o_ones, pop_below(out7_mask, 5));
            end
        end
        tb_start = 1'b1;
        tick();
        sweep_and_check("after_abort", 1, 1'b0, -1);
    endtask

    task automatic test_start_abort_idle();
        sel_b = 1'b0;
        tb_start = 1'b1;
        tb_abort = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if (o_busy !== 1'b0 || o_vec !== 5'd0 || o_done !== 1'b0) begin
                n_fail++;
                $display("FAIL start_abort_idle: busy=%b vec=%0d done=%b, want busy=0 vec=0 done=0",
                         o_busy, o_vec, o_done);
            end
        end
        tb_start = 1'b0;
        tb_abort = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_sweep();
        sel_b = 1'b0;
        out7_mask = NOMINAL;
        sor3_mask = ~NOMINAL;
        tb_start = 1'b1;
        tick();
        tb_start = 1'b0;
        repeat (10) tick();
        n_checks++;
        if (o_vec !== 5'd10 || o_ones !== 6'(pop_below(out7_mask, 10))) begin
            n_fail++;
            $display("FAIL rst_mid_pre: vec=%0d ones=%0d, want vec=10 ones=%0d", o_vec, o_ones, pop_below(out7_mask, 10));
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (o_vec !== 5'd0 || o_busy !== 1'b0 || o_done !== 1'b0 || o_ones !== 6'd0 ||
            o_mm !== 6'd0 || o_flag !== 1'b0 || o_first !== 5'd0) begin
            n_fail++;
            $display("FAIL rst_mid_async: vec=%0d busy=%b done=%b ones=%0d mm=%0d flag=%b first=%0d, want all 0",
                     o_vec, o_busy, o_done, o_ones, o_mm, o_flag, o_first);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (o_busy !== 1'b0 || o_done !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_mid_after: busy=%b done=%b, want busy=0 done=0", o_busy, o_done);
            end
        end
    endtask

    task automatic test_back_to_back();
        sel_b = 1'b0;
        out7_mask = $urandom;
        sor3_mask = $urandom;
        tb_start = 1'b1;
        tick();
        sweep_and_check("b2b_first", 1, 1'b1, -1);
        tick();
        n_checks++;
        if (o_busy !== 1'b1 || o_vec !== 5'd0 || o_done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_restart: busy=%b vec=%0d done=%b, want busy=1 vec=0 done=0", o_busy, o_vec, o_done);
        end
        sweep_and_check("b2b_second", 1, 1'b0, -1);
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            sel_b = 1'($urandom_range(0, 1));
            out7_mask = $urandom;
            sor3_mask = ($urandom_range(0, 2) == 0) ? out7_mask : (out7_mask ^ ($urandom & $urandom));
            tb_start = 1'b1;
            tick();
            sweep_and_check("random", sel_b ? 3 : 1, 1'b0, -1);
        end
        sel_b = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_nominal();
        test_forced_disagreement();
        test_single_fault();
        test_abort();
        test_start_abort_idle();
        test_reset_mid_sweep();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
